if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage 16-bit pipeline: owns the PC, drives the
//  combinational instruction memory address, and registers {ir, pc, valid} into the IF/ID
//  latch consumed by decode. Handles start, stall, taken-branch redirect/flush, and HALT stop.
// PARAMETERS
//  PC_W       8   PC / IM address width
//  IR_W       16  instruction width
//  BR_SHADOW  2   cycles from fetch until the branch in EX resolves (HALT commit delay)
// PORTS
//  clock          in   1     single clock, rising edge
//  reset          in   1     asynchronous, active-low
//  start          in   1     1-cycle pulse: begin fetching from PC=0 (ignored unless IDLE)
//  stall          in   1     hazard unit: hold PC and IF/ID contents
//  branch_taken   in   1     EX resolved taken jump (JUMP/JNZ/...): redirect + flush
//  branch_target  in   PC_W  redirect address
//  im_addr        out  PC_W  to instruction memory, = pc register (combinational IM)
//  im_data        in   IR_W  instruction word returned same cycle
//  id_ir          out  IR_W  IF/ID instruction; `NOP when not valid
//  id_pc          out  PC_W  address of id_ir
//  id_valid       out  1     id_ir is a real instruction
//  halted         out  1     HALT committed; fetch stopped
// BEHAVIOUR
//  Reset (reset=0, async): pc=0, id_ir=`NOP, id_pc=0, id_valid=0, halted=0, state=IDLE.
//  States: IDLE -> RUN on start. RUN -> HWAIT when im_data[15:11]==`HALT and fetch advances.
//   HWAIT -> HALTED after BR_SHADOW cycles; HWAIT -> RUN on branch_taken. HALTED: terminal
//   until reset; start ignored.
//  Per-cycle priority in RUN/HWAIT: branch_taken > stall > advance.
//   branch_taken: pc<=branch_target; id_ir<=`NOP, id_valid<=0 (flush); overrides stall;
//     HWAIT cancels, shadow counter cleared, state<=RUN.
//   stall (no branch): pc, id_* unchanged; HWAIT counter also frozen.
//   advance: id_ir<=im_data, id_pc<=pc, id_valid<=1; pc<=pc+1 modulo 2^PC_W (0xFF wraps 0x00).
//  HALT fetch: HALT itself is latched (valid) into IF/ID; pc is NOT incremented; subsequent
//   non-stall cycles in HWAIT/HALTED load `NOP, id_valid=0. halted=1 registered on HWAIT->HALTED.
//  IDLE: pc held at 0, IF/ID holds `NOP/valid=0; branch_taken and stall ignored.
//  Latency: instruction at pc appears on id_ir one clock after pc presents it.
//  start coincident with stall: enters RUN, first fetch waits for stall low.
//  Reset mid-operation: all state returns to reset values immediately; fetch restarts only
//   after a new start pulse.
//  All outputs except im_addr are registers; im_addr is wire from pc.
// STRUCTURE
//  Opcodes (`HALT, `NOP, jump opcodes) and field positions come from the shared define.v
//  package; add `OP_MSB/`OP_LSB (15/11) there rather than hard-coding here.
//  One sub-module: if_id_reg (IF/ID latch with hold/flush inputs); FSM + PC logic stay
//  in if_stage.
// TESTING
//  reset low then start pulse -> im_addr 0,1,2,... each clock; id_pc trails by 1, id_valid=1.
//  stall=1 for 3 cycles at pc=4 -> im_addr stays 4, id_ir/id_pc frozen; resumes pc=5 after.
//  branch_taken=1, target=0x02, stall=1 same cycle -> next pc=0x02, id_valid=0, id_ir=`NOP.
//  IM holds HALT at 0x06, no branch -> pc sticks at 6, id_ir=HALT once, halted=1 after 2 cycles.
//  HALT at 0x06 with branch_taken target 0x10 one cycle later -> state RUN, pc=0x10, halted=0.
//  pc=0xFF advance -> pc wraps 0x00; reset asserted mid-RUN -> outputs to reset values async.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared ISA definitions for the fetch stage: opcode field position, opcodes, FSM states.
package if_stage_pkg;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;

  localparam logic [4:0]  OP_NOP   = 5'h00;
  localparam logic [4:0]  OP_HALT  = 5'h1F;
  localparam logic [15:0] NOP_INSN = {OP_NOP, 11'h000};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HWAIT,
    S_HALTED
  } if_state_e;

  function automatic logic is_halt(input logic [OP_MSB:0] ir);
    return ir[OP_MSB:OP_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: control from hazard/EX, instruction memory port, IF/ID latch outputs.
interface if_stage_if #(
  parameter int PC_W = 8,
  parameter int IR_W = 16
);
  logic            start;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] im_addr;
  logic [IR_W-1:0] im_data;
  logic [IR_W-1:0] id_ir;
  logic [PC_W-1:0] id_pc;
  logic            id_valid;
  logic            halted;

  modport master (
    input  start, stall, branch_taken, branch_target, im_data,
    output im_addr, id_ir, id_pc, id_valid, halted
  );

  modport slave (
    output start, stall, branch_taken, branch_target, im_data,
    input  im_addr, id_ir, id_pc, id_valid, halted
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline latch. flush beats hold; a flush inserts a NOP bubble and keeps id_pc.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IR_W = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush,
  input  logic [IR_W-1:0] ir_in,
  input  logic [PC_W-1:0] pc_in,
  output logic [IR_W-1:0] ir,
  output logic [PC_W-1:0] pc,
  output logic            valid
);

  logic [IR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q    <= IR_W'(NOP_INSN);
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      ir_d    = IR_W'(NOP_INSN);
      valid_d = 1'b0;
    end else if (!hold) begin
      ir_d    = ir_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end

  assign ir    = ir_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, start/stall/redirect/HALT control FSM, feeds the IF/ID latch.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int IR_W      = 16,
  parameter int BR_SHADOW = 2
) (
  input  logic      clock,
  input  logic      reset,
  if_stage_if.master bus
);

  localparam int              CNT_W    = (BR_SHADOW > 1) ? $clog2(BR_SHADOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BR_SHADOW - 1);

  if_state_e        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             id_hold, id_flush;
  logic             halt_fetch, shadow_done;

  assign halt_fetch  = is_halt(bus.im_data[OP_MSB:0]);
  assign shadow_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (!bus.branch_taken && !bus.stall && halt_fetch) state_d = S_HWAIT;
      S_HWAIT: begin
        if (bus.branch_taken)             state_d = S_RUN;
        else if (!bus.stall && shadow_done) state_d = S_HALTED;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Priority in RUN/HWAIT: branch redirect, then stall, then advance.
  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    id_hold  = 1'b1;
    id_flush = 1'b0;
    case (state_q)
      S_RUN: begin
        if (bus.branch_taken) begin
          pc_d     = bus.branch_target;
          id_flush = 1'b1;
        end else if (!bus.stall) begin
          id_hold = 1'b0;
          // HALT is latched but the PC parks on it.
          if (!halt_fetch) pc_d = pc_q + PC_W'(1);
        end
      end
      S_HWAIT: begin
        if (bus.branch_taken) begin
          pc_d     = bus.branch_target;
          id_flush = 1'b1;
          cnt_d    = '0;
        end else if (!bus.stall) begin
          id_flush = 1'b1;
          if (shadow_done) begin
            cnt_d    = '0;
            halted_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_HALTED: id_flush = !bus.stall;
      default: ;
    endcase
  end

  if_id_reg #(.PC_W(PC_W), .IR_W(IR_W)) u_if_id (
    .clock (clock),
    .reset (reset),
    .hold  (id_hold),
    .flush (id_flush),
    .ir_in (bus.im_data),
    .pc_in (pc_q),
    .ir    (bus.id_ir),
    .pc    (bus.id_pc),
    .valid (bus.id_valid)
  );

  assign bus.im_addr = pc_q;
  assign bus.halted  = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: one vector table for the main program run plus corner sequences.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  if_stage_if #(.PC_W(8), .IR_W(16)) bus ();
  if_stage #(.PC_W(8), .IR_W(16), .BR_SHADOW(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] imem [256];
  assign bus.im_data = imem[bus.im_addr];

  localparam logic [15:0] HALT_W = 16'hF800;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start, stall, br;
    logic [7:0] tgt;
    logic [7:0] ea;
    logic [15:0] eir;
    logic [7:0] epc;
    logic       pc_care, ev, eh;
  } vec_t;

  vec_t vq[$];

  function automatic logic [15:0] insn(input logic [7:0] a);
    return {8'h08, a};
  endfunction

  function automatic vec_t v(input logic s, st, b, input logic [7:0] t, ea,
                             input logic [15:0] eir, input logic [7:0] epc,
                             input logic pcc, ev, eh);
    vec_t r;
    r.start = s; r.stall = st; r.br = b; r.tgt = t;
    r.ea = ea; r.eir = eir; r.epc = epc; r.pc_care = pcc; r.ev = ev; r.eh = eh;
    return r;
  endfunction

  task automatic drive(input logic s, st, b, input logic [7:0] t);
    bus.start = s; bus.stall = st; bus.branch_taken = b; bus.branch_target = t;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] ea, input logic [15:0] eir,
                       input logic [7:0] epc, input logic pcc, ev, eh);
    checks++;
    if (bus.im_addr !== ea || bus.id_ir !== eir || (pcc && bus.id_pc !== epc) ||
        bus.id_valid !== ev || bus.halted !== eh) begin
      errors++;
      $display("FAIL %s: got addr=%h ir=%h pc=%h v=%b h=%b want addr=%h ir=%h pc=%h v=%b h=%b",
               nm, bus.im_addr, bus.id_ir, bus.id_pc, bus.id_valid, bus.halted,
               ea, eir, epc, ev, eh);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    #1;
    check("reset", 8'h00, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Reset, start, then n plain advance cycles.
  task automatic start_and_run(input int n);
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = insn(8'(i));
    imem[6] = HALT_W;
    #3;

    // start, run, 3-cycle stall at pc 4, branch+stall to 2, run into HALT at 6.
    vq.push_back(v(1,0,0,8'h00, 8'h00, 16'h0000, 8'h00, 1, 0, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h01, insn(0),  8'h00, 1, 1, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h02, insn(1),  8'h01, 1, 1, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h03, insn(2),  8'h02, 1, 1, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h04, insn(3),  8'h03, 1, 1, 0));
    vq.push_back(v(0,1,0,8'h00, 8'h04, insn(3),  8'h03, 1, 1, 0));
    vq.push_back(v(0,1,0,8'h00, 8'h04, insn(3),  8'h03, 1, 1, 0));
    vq.push_back(v(0,1,0,8'h00, 8'h04, insn(3),  8'h03, 1, 1, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h05, insn(4),  8'h04, 1, 1, 0));
    vq.push_back(v(0,1,1,8'h02, 8'h02, 16'h0000, 8'h00, 0, 0, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h03, insn(2),  8'h02, 1, 1, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h04, insn(3),  8'h03, 1, 1, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h05, insn(4),  8'h04, 1, 1, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h06, insn(5),  8'h05, 1, 1, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h06, HALT_W,   8'h06, 1, 1, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h06, 16'h0000, 8'h00, 0, 0, 0));
    vq.push_back(v(0,0,0,8'h00, 8'h06, 16'h0000, 8'h00, 0, 0, 1));
    vq.push_back(v(1,0,0,8'h00, 8'h06, 16'h0000, 8'h00, 0, 0, 1));
    vq.push_back(v(0,0,1,8'h20, 8'h06, 16'h0000, 8'h00, 0, 0, 1));

    do_reset();
    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].stall, vq[i].br, vq[i].tgt);
      step();
      check($sformatf("vec%0d", i), vq[i].ea, vq[i].eir, vq[i].epc,
            vq[i].pc_care, vq[i].ev, vq[i].eh);
    end

    // HALT latched, then taken branch cancels the halt.
    start_and_run(7);
    check("halt_latched", 8'h06, HALT_W, 8'h06, 1, 1, 0);
    drive(1'b0, 1'b0, 1'b1, 8'h10);
    step();
    check("halt_cancel", 8'h10, 16'h0000, 8'h00, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("after_cancel", 8'h11, insn(8'h10), 8'h10, 1, 1, 0);
    for (int k = 0; k < 3; k++) step();
    check("still_running", 8'h14, insn(8'h13), 8'h13, 1, 1, 0);

    // Stall in HWAIT freezes the shadow counter.
    start_and_run(7);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) step();
    check("hwait_stall", 8'h06, HALT_W, 8'h06, 1, 1, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("hwait_cnt1", 8'h06, 16'h0000, 8'h00, 0, 0, 0);
    step();
    check("hwait_done", 8'h06, 16'h0000, 8'h00, 0, 0, 1);

    // start coincident with stall.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    check("start_stall", 8'h00, 16'h0000, 8'h00, 1, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("start_release", 8'h01, insn(0), 8'h00, 1, 1, 0);

    // PC wrap 0xFF -> 0x00.
    start_and_run(1);
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    step();
    check("jump_ff", 8'hFF, 16'h0000, 8'h00, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("wrap", 8'h00, insn(8'hFF), 8'hFF, 1, 1, 0);
    step();
    check("post_wrap", 8'h01, insn(0), 8'h00, 1, 1, 0);

    // Async reset mid-RUN, then IDLE ignores branch/stall without a start.
    start_and_run(3);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 8'h00, 16'h0000, 8'h00, 1, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 8'h30);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("idle_ignore", 8'h00, 16'h0000, 8'h00, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
